// File: rtl/mfp_pkg.sv
// Shared constants and types for the MFP68901 interrupt controller.
package mfp_pkg;

  localparam int unsigned NUM_SRC      = 16;
  localparam logic [7:0]  SPUR_VEC_DEF = 8'h18;
  localparam int unsigned VR_S_BIT     = 3;

  localparam logic [3:0] ADDR_IERA = 4'd0;
  localparam logic [3:0] ADDR_IERB = 4'd1;
  localparam logic [3:0] ADDR_IPRA = 4'd2;
  localparam logic [3:0] ADDR_IPRB = 4'd3;
  localparam logic [3:0] ADDR_ISRA = 4'd4;
  localparam logic [3:0] ADDR_ISRB = 4'd5;
  localparam logic [3:0] ADDR_IMRA = 4'd6;
  localparam logic [3:0] ADDR_IMRB = 4'd7;
  localparam logic [3:0] ADDR_VR   = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    DRIVE,
    WAIT_REL
  } irq_state_e;

endpackage

// File: rtl/mfp_prio_enc.sv
// Fixed-priority encoder: highest set bit wins, valid flags a non-empty input.
module mfp_prio_enc
  import mfp_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  output logic [3:0]         idx,
  output logic               valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (req[i]) begin
        idx   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mfp_irq_ctrl.sv
// MFP68901 interrupt controller: IER/IPR/ISR/IMR/VR registers, fixed priority, level IACK handshake.
// Optional daisy chain via `define MFP_IRQ_DAISY_EN (default build ignores IEI_N, IEO_N tied high).
module mfp_irq_ctrl
  import mfp_pkg::*;
#(
  parameter logic [7:0] SPUR_VEC = SPUR_VEC_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLK_EN,
  input  logic [NUM_SRC-1:0] SRC_EDGE,
  input  logic               REG_WE,
  input  logic [3:0]         REG_ADDR,
  input  logic [7:0]         REG_DI,
  output logic [7:0]         REG_DO,
  output logic               IRQ,
  input  logic               IACK,
  output logic [7:0]         VEC_O,
  output logic               VEC_VALID,
  input  logic               IEI_N,
  output logic               IEO_N
);

  logic [NUM_SRC-1:0] ier, ipr, isr, imr;
  logic [NUM_SRC-1:0] ier_n, ipr_n, isr_n, imr_n;
  logic [7:0]         vr, vr_n;
  logic [7:0]         vec_q, vec_n;
  logic               vv_q, vv_n, irq_q, irq_n;
  logic               iack_arm, iack_arm_n;
  logic               ack_fire;
  irq_state_e         state, state_n;

  logic [3:0] w_idx, isr_idx;
  logic       e_valid, isr_valid, blocked, iei_ok;

  mfp_prio_enc u_enc_e (
    .req   (ipr & imr),
    .idx   (w_idx),
    .valid (e_valid)
  );

  mfp_prio_enc u_enc_isr (
    .req   (isr),
    .idx   (isr_idx),
    .valid (isr_valid)
  );

  assign blocked = isr_valid && (w_idx <= isr_idx);

`ifdef MFP_IRQ_DAISY_EN
  assign iei_ok = ~IEI_N;
  assign IEO_N  = ~(~IEI_N & (~e_valid | blocked));
`else
  logic iei_unused;
  assign iei_unused = IEI_N;
  assign iei_ok     = 1'b1;
  assign IEO_N      = 1'b1;
`endif

  // Handshake: the acknowledge effects are applied on the LATCH->DRIVE edge
  // so VEC_VALID appears two cycles after IACK and IPR already reads cleared in DRIVE.
  always_comb begin
    state_n  = state;
    vec_n    = vec_q;
    vv_n     = vv_q;
    ack_fire = 1'b0;
    case (state)
      IDLE:     if (IACK && iack_arm && iei_ok) state_n = LATCH;
      LATCH: begin
        state_n  = DRIVE;
        ack_fire = e_valid;
        vec_n    = e_valid ? {vr[7:4], w_idx} : SPUR_VEC;
        vv_n     = 1'b1;
      end
      DRIVE: begin
        if (!IACK) begin
          vv_n    = 1'b0;
          state_n = IDLE;
        end else begin
          state_n = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!IACK) begin
          vv_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default:  state_n = IDLE;
    endcase
  end

  // Order matters: clears, then edge sets, then IER-zero discard last.
  always_comb begin
    ier_n = ier;
    ipr_n = ipr;
    isr_n = isr;
    imr_n = imr;
    vr_n  = vr;
    if (REG_WE) begin
      case (REG_ADDR)
        ADDR_IERA: ier_n[15:8] = REG_DI;
        ADDR_IERB: ier_n[7:0]  = REG_DI;
        ADDR_IPRA: ipr_n[15:8] = ipr[15:8] & REG_DI;
        ADDR_IPRB: ipr_n[7:0]  = ipr[7:0] & REG_DI;
        ADDR_ISRA: isr_n[15:8] = isr[15:8] & REG_DI;
        ADDR_ISRB: isr_n[7:0]  = isr[7:0] & REG_DI;
        ADDR_IMRA: imr_n[15:8] = REG_DI;
        ADDR_IMRB: imr_n[7:0]  = REG_DI;
        ADDR_VR:   vr_n        = REG_DI;
        default:   ;
      endcase
    end
    if (ack_fire) begin
      ipr_n[w_idx] = 1'b0;
      if (vr[VR_S_BIT]) isr_n[w_idx] = 1'b1;
    end
    ipr_n = ipr_n | (SRC_EDGE & ier);
    ipr_n = ipr_n & ier_n;
  end

  assign irq_n      = e_valid && !blocked && (state == IDLE) && iei_ok;
  assign iack_arm_n = iack_arm | ~IACK;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      ier      <= '0;
      ipr      <= '0;
      isr      <= '0;
      imr      <= '0;
      vr       <= '0;
      vec_q    <= '0;
      vv_q     <= 1'b0;
      irq_q    <= 1'b0;
      iack_arm <= 1'b0;
    end else if (CLK_EN) begin
      state    <= state_n;
      ier      <= ier_n;
      ipr      <= ipr_n;
      isr      <= isr_n;
      imr      <= imr_n;
      vr       <= vr_n;
      vec_q    <= vec_n;
      vv_q     <= vv_n;
      irq_q    <= irq_n;
      iack_arm <= iack_arm_n;
    end
  end

  always_comb begin
    case (REG_ADDR)
      ADDR_IERA: REG_DO = ier[15:8];
      ADDR_IERB: REG_DO = ier[7:0];
      ADDR_IPRA: REG_DO = ipr[15:8];
      ADDR_IPRB: REG_DO = ipr[7:0];
      ADDR_ISRA: REG_DO = isr[15:8];
      ADDR_ISRB: REG_DO = isr[7:0];
      ADDR_IMRA: REG_DO = imr[15:8];
      ADDR_IMRB: REG_DO = imr[7:0];
      ADDR_VR:   REG_DO = vr;
      default:   REG_DO = '0;
    endcase
  end

  assign IRQ       = irq_q;
  assign VEC_O     = vec_q;
  assign VEC_VALID = vv_q;

endmodule

// File: doc/mfp_irq_ctrl.md
Name: mfp_irq_ctrl

Overview:
Interrupt controller for the MFP68901 block. It collects one-cycle event pulses from the four mfp_timer instances (T_O_PULSE), the GPIO edge detectors and the USART. It keeps the MFP enable, pending, mask and in-service registers for 16 channels. It arbitrates by fixed priority, drives the CPU interrupt request and supplies the vector through a level IACK handshake.

Parameters:
NUM_SRC, 16, number of interrupt channels; fixed at 16 for register mapping, channel 15 highest priority
SPUR_VEC, 8'h18, vector returned when IACK arrives with no eligible channel

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
CLK_EN  in  1  MFP clock enable; all state updates qualified by it (RST excepted)
SRC_EDGE  in  16  event pulses, one CLK_EN cycle wide, bit n = channel n
REG_WE  in  1  register write strobe
REG_ADDR  in  4  register select: 0 IERA(15:8), 1 IERB(7:0), 2 IPRA, 3 IPRB, 4 ISRA, 5 ISRB, 6 IMRA, 7 IMRB, 8 VR
REG_DI  in  8  write data
REG_DO  out  8  read data for REG_ADDR, combinational; unmapped addresses read 8'h00
IRQ  out  1  interrupt request, active-high, registered
IACK  in  1  interrupt acknowledge, level, held until VEC_VALID is seen
VEC_O  out  8  vector, stable while VEC_VALID=1
VEC_VALID  out  1  vector valid, held until IACK falls
IEI_N  in  1  daisy-chain enable in (see Optional Feature)
IEO_N  out  1  daisy-chain enable out

Behaviour:
- Reset: IER, IPR, ISR, IMR = 0; VR = 8'h00; IRQ = 0, VEC_VALID = 0, VEC_O = 8'h00, IEO_N = 1; FSM = IDLE.
- Pending set: SRC_EDGE[n] & IER[n] sets IPR[n]. Edges on disabled channels are lost.
- IER write: any bit written 0 also clears the matching IPR bit in the same cycle.
- IPR/ISR writes: 0 bits clear, 1 bits leave unchanged. IMR/IER/VR are plain writes.
- Precedence in one cycle: a set from SRC_EDGE beats a clear from an IPR write or from acknowledge. A set on a channel whose IER bit is being written 0 is discarded.
- Eligible set E = IPR & IMR. Winner W = highest index in E.
- Blocking: W is blocked if W is at or below the highest set ISR bit.
- IRQ (registered, 1-cycle latency): IRQ = (E != 0) & ~blocked & FSM==IDLE.
- VR[3] = S, software end-of-interrupt. VR[7:4] = vector base. VR[2:0] are stored and read back.
- FSM:
  IDLE: IACK=1 → LATCH.
  LATCH: freeze W and the eligibility flag → DRIVE.
  DRIVE: VEC_O = {VR[7:4], W[3:0]}, or SPUR_VEC if nothing eligible. VEC_VALID = 1. Clear IPR[W]. If S=1, set ISR[W] → WAIT_REL.
  WAIT_REL: hold VEC_O and VEC_VALID. When IACK=0, drop VEC_VALID → IDLE.
- Latency: IACK rise to VEC_VALID = 2 CLK_EN cycles.
- IACK dropped in LATCH: the FSM still completes DRIVE, then returns to IDLE one cycle later.
- Spurious acknowledge: no IPR or ISR change.
- Register reads are live values; an IPR read during DRIVE shows the bit already cleared.
- RST asserted mid-handshake: immediate return to reset values; any outstanding IACK is ignored until it falls and rises again.
- REG_WE and an acknowledge clear on the same IPR bit: the result is cleared unless a SRC_EDGE sets it.

Optional Feature:
MFP_IRQ_DAISY_EN
- Defined: the FSM leaves IDLE only when IEI_N=0. IRQ is also gated by IEI_N=0. IEO_N = 0 when IEI_N=0 and (E==0 or blocked). IEO_N = 1 otherwise.
- Undefined: IEI_N is ignored and treated as 0; IEO_N is tied to 1.

Decomposition:
- Package mfp_pkg: register address constants (IERA..VR), FSM state enum (IDLE, LATCH, DRIVE, WAIT_REL), NUM_SRC, SPUR_VEC default, S-bit index in VR.
- Sub-module mfp_prio_enc: 16-bit input to 4-bit index plus valid, highest index wins. Instantiate twice, once for E and once for ISR.

Test Plan:
- Reset → all registers read 8'h00; IRQ=0; VEC_VALID=0; IEO_N=1.
- IERA=8'h20, IMRA=8'h20, pulse SRC_EDGE[13] (Timer A), VR=8'h40 → IPRA=8'h20, IRQ=1 next cycle. Raise IACK → VEC_O=8'h4D, VEC_VALID two cycles later. IPRA=8'h00; drop IACK → VEC_VALID=0.
- VR=8'h48 (S=1): ack channel 5 → ISRB=8'h20. Pending channel 4 gives IRQ=0, channel 8 gives IRQ=1. Write ISRB=8'hDF → channel 4 raises IRQ.
- SRC_EDGE[0] in the same cycle as writing IPRB=8'hFE → IPRB bit 0 stays 1. Write IERB=8'h00 → IPRB=8'h00.
- IACK with E=0 → VEC_O=8'h18, IPR/ISR unchanged.
- Assert RST while in WAIT_REL with IACK still high → outputs reset; no new vector until IACK toggles.
